// File: rtl/wb_commit_stage_pkg.sv
// Shared widths and the instruction-pair record used by the writeback/commit stage.
package wb_commit_stage_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    typedef struct packed {
        logic [1:0]        lv;
        logic              we0;
        logic [REG_AW-1:0] rd0;
        logic [XLEN-1:0]   data0;
        logic              we1;
        logic [REG_AW-1:0] rd1;
        logic [XLEN-1:0]   data1;
    } wb_pair_t;

    function automatic logic [1:0] lane_count(input logic [1:0] lv);
        return {1'b0, lv[0]} + {1'b0, lv[1]};
    endfunction

endpackage

// File: rtl/wb_pair_fifo.sv
// Circular buffer of instruction pairs; also exposes every entry ordered youngest-first for forwarding.
module wb_pair_fifo
    import wb_commit_stage_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  wb_pair_t         wr_pair,
    output wb_pair_t         head,
    output wb_pair_t         aged [DEPTH],
    output logic [DEPTH-1:0] aged_valid,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    wb_pair_t      mem [DEPTH];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_pair;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));

    // aged[0] is the most recently pushed pair; only the first count slots are live.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            aged[i]       = mem[wr_ptr - AW'(i + 1)];
            aged_valid[i] = ((AW+1)'(i) < count);
        end
    end

endmodule

// File: rtl/wb_commit_stage.sv
// Dual-lane writeback/commit stage: pair FIFO, conflict-resolved register-file write ports, forwarding.
module wb_commit_stage #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned XLEN   = wb_commit_stage_pkg::XLEN,
    parameter int unsigned REG_AW = wb_commit_stage_pkg::REG_AW,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_lv,
    input  logic                in_we0,
    input  logic                in_we1,
    input  logic [REG_AW-1:0]   in_rd0,
    input  logic [REG_AW-1:0]   in_rd1,
    input  logic [XLEN-1:0]     in_data0,
    input  logic [XLEN-1:0]     in_data1,
    input  logic                hold,
    output logic [REG_AW-1:0]   rd1,
    output logic [XLEN-1:0]     wb_data1,
    output logic                wb_we1,
    output logic [REG_AW-1:0]   rd2,
    output logic [XLEN-1:0]     wb_data2,
    output logic                wb_we2,
    input  logic [4*REG_AW-1:0] fwd_rs,
    output logic [3:0]          fwd_hit,
    output logic [4*XLEN-1:0]   fwd_data,
    output logic [CNT_W-1:0]    retire_cnt,
    output logic                empty,
    output logic                full
);

    wb_commit_stage_pkg::wb_pair_t in_pair;
    wb_commit_stage_pkg::wb_pair_t head;
    wb_commit_stage_pkg::wb_pair_t aged [DEPTH];
    logic [DEPTH-1:0]              aged_valid;
    logic [1:0]                    lv_s;
    logic                          push;
    logic                          pop;

    // Lane1 without lane0 is dropped entirely; rd=0 writes are discarded at entry.
    always_comb begin
        lv_s          = (in_lv == 2'b10) ? 2'b00 : in_lv;
        in_pair.lv    = lv_s;
        in_pair.we0   = lv_s[0] && in_we0 && (in_rd0 != '0);
        in_pair.rd0   = in_rd0;
        in_pair.data0 = in_data0;
        in_pair.we1   = lv_s[1] && in_we1 && (in_rd1 != '0);
        in_pair.rd1   = in_rd1;
        in_pair.data1 = in_data1;
    end

    assign pop      = !hold && !empty;
    assign in_ready = !full || pop;
    assign push     = in_valid && in_ready;

    wb_pair_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .wr_pair    (in_pair),
        .head       (head),
        .aged       (aged),
        .aged_valid (aged_valid),
        .empty      (empty),
        .full       (full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd1        <= '0;
            wb_data1   <= '0;
            wb_we1     <= 1'b0;
            rd2        <= '0;
            wb_data2   <= '0;
            wb_we2     <= 1'b0;
            retire_cnt <= '0;
        end else if (pop) begin
            rd1        <= head.rd0;
            wb_data1   <= head.data0;
            // Older lane yields on a same-destination conflict so the younger result lands.
            wb_we1     <= head.we0 && !(head.we1 && (head.rd0 == head.rd1));
            rd2        <= head.rd1;
            wb_data2   <= head.data1;
            wb_we2     <= head.we1;
            retire_cnt <= retire_cnt + CNT_W'(wb_commit_stage_pkg::lane_count(head.lv));
        end else begin
            wb_we1 <= 1'b0;
            wb_we2 <= 1'b0;
        end
    end

    // Later matches overwrite earlier ones, so scan oldest-to-newest to get newest-first priority.
    always_comb begin
        fwd_hit  = '0;
        fwd_data = '0;
        for (int unsigned k = 0; k < 4; k++) begin : g_slot
            logic [REG_AW-1:0] rs;
            logic              hit;
            logic [XLEN-1:0]   data;
            rs   = fwd_rs[k*REG_AW +: REG_AW];
            hit  = 1'b0;
            data = '0;
            if (wb_we1 && (rd1 == rs)) begin
                hit  = 1'b1;
                data = wb_data1;
            end
            if (wb_we2 && (rd2 == rs)) begin
                hit  = 1'b1;
                data = wb_data2;
            end
            for (int unsigned i = DEPTH; i > 0; i--) begin
                if (aged_valid[i-1]) begin
                    if (aged[i-1].we0 && (aged[i-1].rd0 == rs)) begin
                        hit  = 1'b1;
                        data = aged[i-1].data0;
                    end
                    if (aged[i-1].we1 && (aged[i-1].rd1 == rs)) begin
                        hit  = 1'b1;
                        data = aged[i-1].data1;
                    end
                end
            end
            if (rs == '0) begin
                hit  = 1'b0;
                data = '0;
            end
            fwd_hit[k]                = hit;
            fwd_data[k*XLEN +: XLEN]  = data;
        end
    end

endmodule

// File: tb/tb_wb_commit_stage.sv
// Randomised scoreboard bench for wb_commit_stage against a queue-based transaction model.
module tb_wb_commit_stage;
    import wb_commit_stage_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 32;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_lv;
    logic              in_we0, in_we1;
    logic [REG_AW-1:0] in_rd0, in_rd1;
    logic [XLEN-1:0]   in_data0, in_data1;
    logic              hold;
    logic [REG_AW-1:0] rd1, rd2;
    logic [XLEN-1:0]   wb_data1, wb_data2;
    logic              wb_we1, wb_we2;
    logic [4*REG_AW-1:0] fwd_rs;
    logic [3:0]        fwd_hit;
    logic [4*XLEN-1:0] fwd_data;
    logic [CNT_W-1:0]  retire_cnt;
    logic              empty, full;

    wb_commit_stage #(
        .DEPTH  (DEPTH),
        .XLEN   (XLEN),
        .REG_AW (REG_AW),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_lv      (in_lv),
        .in_we0     (in_we0),
        .in_we1     (in_we1),
        .in_rd0     (in_rd0),
        .in_rd1     (in_rd1),
        .in_data0   (in_data0),
        .in_data1   (in_data1),
        .hold       (hold),
        .rd1        (rd1),
        .wb_data1   (wb_data1),
        .wb_we1     (wb_we1),
        .rd2        (rd2),
        .wb_data2   (wb_data2),
        .wb_we2     (wb_we2),
        .fwd_rs     (fwd_rs),
        .fwd_hit    (fwd_hit),
        .fwd_data   (fwd_data),
        .retire_cnt (retire_cnt),
        .empty      (empty),
        .full       (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              we1;
        logic [REG_AW-1:0] rd1;
        logic [XLEN-1:0]   d1;
        logic              we2;
        logic [REG_AW-1:0] rd2;
        logic [XLEN-1:0]   d2;
    } wb_exp_t;

    int checks = 0;
    int errors = 0;

    // Model: pending pairs, last committed pair on the ports, retired count.
    wb_pair_t          mq [$];
    wb_exp_t           sb [$];
    logic              m_we1 = 0, m_we2 = 0;
    logic [REG_AW-1:0] m_rd1 = 0, m_rd2 = 0;
    logic [XLEN-1:0]   m_d1 = 0, m_d2 = 0;
    logic [CNT_W-1:0]  m_cnt = 0;
    bit                acc = 0;
    bit                fwd_rand = 1;
    bit                hold_rand = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic wb_pair_t sanitize();
        wb_pair_t p;
        p.lv    = (in_lv == 2'b10) ? 2'b00 : in_lv;
        p.we0   = p.lv[0] && in_we0 && (in_rd0 != 0);
        p.rd0   = in_rd0;
        p.data0 = in_data0;
        p.we1   = p.lv[1] && in_we1 && (in_rd1 != 0);
        p.rd1   = in_rd1;
        p.data1 = in_data1;
        return p;
    endfunction

    function automatic void fwd_model(input logic [REG_AW-1:0] rs, output logic hit, output logic [XLEN-1:0] d);
        hit = 0;
        d   = 0;
        if (rs == 0) return;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].we1 && mq[i].rd1 == rs) begin hit = 1; d = mq[i].data1; return; end
            if (mq[i].we0 && mq[i].rd0 == rs) begin hit = 1; d = mq[i].data0; return; end
        end
        if (m_we2 && m_rd2 == rs) begin hit = 1; d = m_d2; return; end
        if (m_we1 && m_rd1 == rs) begin hit = 1; d = m_d1; return; end
    endfunction

    function automatic void model_reset();
        mq.delete();
        sb.delete();
        m_we1 = 0; m_we2 = 0; m_rd1 = 0; m_rd2 = 0; m_d1 = 0; m_d2 = 0;
        m_cnt = 0;
        acc = 0;
    endfunction

    always @(posedge clk) begin : model
        bit       do_pop, ready;
        wb_pair_t h;
        wb_exp_t  e;
        if (rst_n) begin
            do_pop = !hold && (mq.size() > 0);
            ready  = (mq.size() < DEPTH) || do_pop;
            acc    = in_valid && ready;
            if (do_pop) begin
                h = mq.pop_front();
                m_rd1 = h.rd0; m_d1 = h.data0;
                m_rd2 = h.rd1; m_d2 = h.data1;
                m_we2 = h.we1;
                m_we1 = h.we0 && !(h.we1 && h.rd0 == h.rd1);
                m_cnt = m_cnt + h.lv[0] + h.lv[1];
                if (m_we1 || m_we2) begin
                    e.we1 = m_we1; e.rd1 = m_rd1; e.d1 = m_d1;
                    e.we2 = m_we2; e.rd2 = m_rd2; e.d2 = m_d2;
                    sb.push_back(e);
                end
            end else begin
                m_we1 = 0;
                m_we2 = 0;
            end
            if (acc) mq.push_back(sanitize());
        end
    end

    always @(negedge clk) begin : monitor
        wb_exp_t           e;
        logic              eh;
        logic [XLEN-1:0]   ed;
        if (rst_n) begin
            check("wb_we1", wb_we1, m_we1);
            check("wb_we2", wb_we2, m_we2);
            if (wb_we1 || wb_we2) begin
                if (sb.size() == 0) begin
                    check("unexpected_commit", 1, 0);
                end else begin
                    e = sb.pop_front();
                    if (e.we1) begin
                        check("rd1", rd1, e.rd1);
                        check("wb_data1", wb_data1, e.d1);
                    end
                    if (e.we2) begin
                        check("rd2", rd2, e.rd2);
                        check("wb_data2", wb_data2, e.d2);
                    end
                end
            end
            check("retire_cnt", retire_cnt, m_cnt);
            check("empty", empty, mq.size() == 0);
            check("full", full, mq.size() == DEPTH);
            check("in_ready", in_ready, (mq.size() < DEPTH) || (!hold && mq.size() > 0));
            for (int k = 0; k < 4; k++) begin
                fwd_model(fwd_rs[k*REG_AW +: REG_AW], eh, ed);
                check($sformatf("fwd_hit%0d", k), fwd_hit[k], eh);
                check($sformatf("fwd_data%0d", k), fwd_data[k*XLEN +: XLEN], ed);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
        if (fwd_rand) begin
            for (int k = 0; k < 4; k++) fwd_rs[k*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 7));
        end
        if (hold_rand) hold = ($urandom_range(0, 4) == 0);
    endtask

    task automatic offer(input logic [1:0] lv, input logic we0, input int r0, input int d0,
                         input logic we1, input int r1, input int d1);
        in_valid = 1;
        in_lv    = lv;
        in_we0   = we0; in_rd0 = REG_AW'(r0); in_data0 = XLEN'(d0);
        in_we1   = we1; in_rd1 = REG_AW'(r1); in_data1 = XLEN'(d1);
    endtask

    task automatic wait_acc(output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (!acc && cycles < 60);
        if (!acc) check("accept_timeout", 0, 1);
        in_valid = 0;
    endtask

    task automatic send(input logic [1:0] lv, input logic we0, input int r0, input int d0,
                        input logic we1, input int r1, input int d1);
        int c;
        offer(lv, we0, r0, d0, we1, r1, d1);
        wait_acc(c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic reset_checks();
        check("rst_we1", wb_we1, 0);
        check("rst_we2", wb_we2, 0);
        check("rst_rd1", rd1, 0);
        check("rst_rd2", rd2, 0);
        check("rst_data1", wb_data1, 0);
        check("rst_data2", wb_data2, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_retire", retire_cnt, 0);
        check("rst_fwd_hit", fwd_hit, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin : driver
        int c;
        rst_n = 0; in_valid = 0; in_lv = 0; in_we0 = 0; in_we1 = 0;
        in_rd0 = 0; in_rd1 = 0; in_data0 = 0; in_data1 = 0; hold = 0;
        fwd_rs = 0;
        #23;
        fwd_rs = {5'd7, 5'd6, 5'd5, 5'd1};
        #1;
        reset_checks();
        @(negedge clk);
        rst_n = 1;

        // Single pair, two distinct writes.
        fwd_rand = 0;
        fwd_rs = {5'd0, 5'd0, 5'd6, 5'd5};
        send(2'b11, 1, 5, 'h11, 1, 6, 'h22);
        #1;
        check("pend_fwd_x5", fwd_data[0 +: XLEN], 'h11);
        step();
        #1;
        check("lat_we1", wb_we1, 1);
        check("lat_we2", wb_we2, 1);
        check("lat_rd1", rd1, 5);
        check("lat_rd2", rd2, 6);
        check("retire_after_pair", retire_cnt, 2);
        idle(2);

        // Same-destination conflict: younger lane wins.
        fwd_rs = {5'd0, 5'd0, 5'd0, 5'd7};
        send(2'b11, 1, 7, 'hA, 1, 7, 'hB);
        #1;
        check("conf_fwd_hit_q", fwd_hit[0], 1);
        check("conf_fwd_data_q", fwd_data[0 +: XLEN], 'hB);
        step();
        #1;
        check("conf_we1", wb_we1, 0);
        check("conf_we2", wb_we2, 1);
        check("conf_data2", wb_data2, 'hB);
        check("conf_fwd_data_p", fwd_data[0 +: XLEN], 'hB);
        idle(2);

        // Hold with FIFO filled, then release into back-to-back streaming.
        hold = 1;
        send(2'b11, 1, 1, 'h101, 1, 2, 'h102);
        send(2'b11, 1, 3, 'h103, 1, 4, 'h104);
        offer(2'b01, 1, 8, 'h200, 0, 0, 0);
        idle(3);
        #1;
        check("hold_full", full, 1);
        check("hold_ready", in_ready, 0);
        hold = 0;
        #1;
        check("release_ready", in_ready, 1);
        wait_acc(c);
        for (int i = 0; i < 8; i++) begin
            offer(2'b11, 1, 8 + i, 'h300 + i, 1, 16 + i, 'h400 + i);
            wait_acc(c);
            check("stream_accept_cycles", c, 1);
        end
        idle(4);

        // rd=0 writes, single-lane and illegal lane-valid patterns.
        begin
            logic [CNT_W-1:0] base;
            base = retire_cnt;
            send(2'b01, 1, 0, 'h55, 1, 9, 'h66);
            send(2'b10, 1, 9, 'h77, 1, 10, 'h88);
            send(2'b11, 1, 0, 'h99, 1, 0, 'hAA);
            fwd_rs = '0;
            #1;
            check("rs0_no_hit", fwd_hit, 0);
            idle(4);
            check("retire_lv01_lv10_lv11", retire_cnt, base + 3);
        end

        // Random traffic with random hold and forwarding reads; reset mid-stream.
        fwd_rand = 1;
        hold_rand = 1;
        for (int it = 0; it < 500; it++) begin
            if (it == 250) begin
                offer(2'b11, 1, 3, 'h1234, 1, 4, 'h5678);
                step();
                rst_n = 0;
                model_reset();
                #1;
                reset_checks();
                in_valid = 0;
                hold = 0;
                hold_rand = 0;
                step();
                rst_n = 1;
                send(2'b11, 1, 12, 'hCAFE, 1, 13, 'hBEEF);
                step();
                #1;
                check("post_rst_we1", wb_we1, 1);
                check("post_rst_rd1", rd1, 12);
                check("post_rst_data2", wb_data2, 'hBEEF);
                hold_rand = 1;
            end
            if ($urandom_range(0, 3) != 0) begin
                send(2'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, 7), $urandom,
                     1'($urandom), $urandom_range(0, 7), $urandom);
            end else begin
                step();
            end
        end

        hold_rand = 0;
        hold = 0;
        idle(6);
        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_commit_stage.md
Name: wb_commit_stage

Overview:
Dual-lane writeback/commit stage that sits directly upstream of the two-write-port register file. It buffers completed instruction pairs from the memory stage in a small FIFO and drives the register file's two write ports one pair per cycle. It resolves same-destination conflicts so the younger lane's result is the one that lands. It supplies forwarding data for the four decode read addresses, covering results that are pending but not yet written.

Parameters:
DEPTH, 2, FIFO depth in instruction pairs (power of two, at least 2)
XLEN, 32, data width
REG_AW, 5, register address width
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  a pair is offered
in_ready  out  1  the stage can accept the pair this cycle
in_lv  in  2  lane valid bits; bit0 = lane0 (older), bit1 = lane1 (younger)
in_we0, in_we1  in  1 each  per-lane register write request
in_rd0, in_rd1  in  REG_AW each  per-lane destination register
in_data0, in_data1  in  XLEN each  per-lane result
hold  in  1  freezes commit (debug or external stall)
rd1, wb_data1, wb_we1  out  REG_AW/XLEN/1  write port 1, carries lane0
rd2, wb_data2, wb_we2  out  REG_AW/XLEN/1  write port 2, carries lane1
fwd_rs  in  4*REG_AW  four read addresses; slot k = bits [5k+4:5k]
fwd_hit  out  4  slot k matches a pending write
fwd_data  out  4*XLEN  forwarded data for slot k
retire_cnt  out  CNT_W  count of retired instructions
empty, full  out  1 each  FIFO status

Behaviour:
- Reset (async, rst_n=0): FIFO pointers and count go to 0; all write-port outputs go to 0; retire_cnt=0; fwd_hit=0. Any in-flight pairs are discarded.
- Entry sanitising on push:
  - A lane with lv=0 stores we=0.
  - Any lane with rd=0 stores we=0.
  - in_lv=2'b10 is illegal (lane1 without lane0); the stage treats it as 2'b00.
- Handshake:
  - pop = !hold && !empty.
  - in_ready = !full || pop.
  - push = in_valid && in_ready.
  - Push and pop in the same cycle leaves the count unchanged, including when the FIFO is full.
  - An offered pair is held by the producer until in_ready.
- Write outputs are registered:
  - On pop, the head pair loads into the port registers.
  - wb_we1 = we0 && !(we1 && rd0==rd1). The older write is suppressed on a conflict, so the younger result lands; the register file's port-1-priority rule is never exercised.
  - With no pop (empty or hold), wb_we1 = wb_we2 = 0 next cycle; rd and data hold their last values.
- Latency with an empty FIFO and hold=0:
  - Pushed at edge N.
  - On the ports after edge N+1.
  - In the register file at edge N+2.
- Forwarding (combinational), per slot:
  - Search order, newest first: FIFO entries youngest to oldest (lane1 before lane0 within an entry), then port-2 register, then port-1 register.
  - Only entries with we=1 participate.
  - fwd_rs=0 never hits.
  - No hit gives fwd_hit=0 and fwd_data=0.
- retire_cnt adds popcount(head lv) on each pop. It counts all valid lanes, with or without a write, and wraps modulo 2^CNT_W.
- empty = (count==0); full = (count==DEPTH).
- Pointers wrap modulo DEPTH.

Decomposition:
- Shared package: XLEN, REG_AW, and the wb_pair_t struct {lv[2], we0, rd0, data0, we1, rd1, data1}.
- One sub-module is natural: wb_pair_fifo (parameterised circular buffer exposing all entries plus age-ordered valid bits for the forwarding search).
- Conflict resolution, forwarding mux and counter live in the top module.

Test Plan:
- Single pair lv=11, x5=0x11, x6=0x22 -> edge N+2 ports show we1/we2=1, rd1=5, rd2=6; retire_cnt=2.
- Both lanes write x7 (0xA, 0xB) -> wb_we1=0, wb_we2=1 with data 0xB; fwd_rs slot0=7 returns 0xB while pending.
- Hold asserted with 2 pairs pushed -> full=1, in_ready=0, wb_we*=0 throughout; release hold -> in_ready=1 immediately, pairs commit in order on consecutive cycles.
- Full FIFO with hold=0 and in_valid held -> push and pop every cycle, count stays at DEPTH, no pair lost (check 8 sequential pairs).
- rd=0 writes and lv=01 -> no write-enable asserted; fwd_rs=0 gives hit=0; retire_cnt increments by 1 for lv=01.
- rst_n pulsed low mid-stream -> outputs 0, empty=1, retire_cnt=0 asynchronously; the first pair after release behaves per the latency rule.
